// File: rtl/count_display_if.sv
// Signal bundle between the 0..99 counter stage (master) and the display stage (slave).
interface count_display_if;
  logic [6:0] count;
  logic       buzzer;
  logic [6:0] seg;
  logic [1:0] an;
  logic       buzzer_out;
  logic       conv_busy;

  modport master (output count, buzzer, input seg, an, buzzer_out, conv_busy);
  modport slave  (input count, buzzer, output seg, an, buzzer_out, conv_busy);
endinterface

// File: rtl/count_display.sv
// Two-digit multiplexed 7-segment driver for the 0..99 counter, with sequential BCD
// conversion and buzzer pulse stretcher. Optional macro DISP_LZ_BLANK_EN blanks a leading zero.
module count_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BUZZ_STRETCH = 25000000,
  parameter bit          SEG_ACT_LOW  = 1'b1
) (
  input logic            clk,
  input logic            result_reset,
  count_display_if.slave bus
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = $clog2(BUZZ_STRETCH + 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(BUZZ_STRETCH);
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = SEG_ACT_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state_q;
  logic [6:0]    s1_q, s2_q, s3_q, last_q, rem_q;
  logic [3:0]    tcnt_q, tens_q, ones_q;
  logic          err_q, busy_q;
  logic [RW-1:0] refresh_q;
  logic          digit_sel_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          b1_q, b2_q, b3_q;
  logic [SW-1:0] stretch_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Repeated-subtraction converter; new inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      tcnt_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q <= bus.count;
      s2_q <= s1_q;
      s3_q <= s2_q;
      case (state_q)
        IDLE: begin
          if ((s2_q == s3_q) && (s3_q != last_q)) begin
            last_q <= s3_q;
            if (s3_q > 7'd99) begin
              err_q <= 1'b1;
            end else begin
              rem_q   <= s3_q;
              tcnt_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= CONV;
            end
          end
        end
        CONV: begin
          if (rem_q >= 7'd10) begin
            rem_q  <= rem_q - 7'd10;
            tcnt_q <= tcnt_q + 4'd1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          tens_q  <= tcnt_q;
          ones_q  <= rem_q[3:0];
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [6:0] pat;
    logic [1:0] en;
    pat = err_q ? 7'h40 : seg7(digit_sel_q ? tens_q : ones_q);
    en  = digit_sel_q ? 2'b10 : 2'b01;
`ifdef DISP_LZ_BLANK_EN
    if (digit_sel_q && (tens_q == 4'd0) && !err_q) begin
      pat = '0;
      en  = '0;
    end
`endif
    seg_d = SEG_ACT_LOW ? ~pat : pat;
    an_d  = SEG_ACT_LOW ? ~en  : en;
  end

  // seg and an share one register stage so a digit change never shows mixed data.
  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      refresh_q   <= '0;
      digit_sel_q <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      if (refresh_q == REFRESH_LAST) begin
        refresh_q   <= '0;
        digit_sel_q <= ~digit_sel_q;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  // A fresh rising edge reloads the stretch counter even if it is still running.
  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      b1_q      <= 1'b0;
      b2_q      <= 1'b0;
      b3_q      <= 1'b0;
      stretch_q <= '0;
    end else begin
      b1_q <= bus.buzzer;
      b2_q <= b1_q;
      b3_q <= b2_q;
      if (b2_q && !b3_q) begin
        stretch_q <= STRETCH_LOAD;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - 1'b1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.conv_busy  = busy_q;
  assign bus.buzzer_out = (stretch_q != '0);

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display with a short refresh and stretch period.
module tb_count_display;

  localparam int RD = 8;
  localparam int BS = 20;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_ONES = 2'b10;
`ifdef DISP_LZ_BLANK_EN
  localparam logic [1:0] AN_TENS0  = 2'b11;
  localparam logic [6:0] SEG_TENS0 = 7'h7F;
`else
  localparam logic [1:0] AN_TENS0  = 2'b01;
  localparam logic [6:0] SEG_TENS0 = 7'h40;
`endif

  logic clk = 1'b0;
  logic result_reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  count_display_if bus ();

  count_display #(
    .REFRESH_DIV (RD),
    .BUZZ_STRETCH(BS),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .result_reset(result_reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_slot(input logic [1:0] want, output logic [6:0] seg_seen, output bit found);
    found    = 1'b0;
    seg_seen = 'x;
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      if (bus.an === want) begin
        found    = 1'b1;
        seg_seen = bus.seg;
        break;
      end
    end
  endtask

  task automatic count_busy(input int window, output int n);
    n = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (bus.conv_busy === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    logic [6:0] s;
    bit f;
    bus.count  = 7'd0;
    bus.buzzer = 1'b0;
    result_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL rst_seg got=%h exp=7f", bus.seg); end
    n_vec++; if (bus.an !== 2'b11) begin n_err++; $display("FAIL rst_an got=%b exp=11", bus.an); end
    n_vec++; if (bus.buzzer_out !== 1'b0) begin n_err++; $display("FAIL rst_buzz got=%b exp=0", bus.buzzer_out); end
    n_vec++; if (bus.conv_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.conv_busy); end
    result_reset = 1'b0;
    repeat (20) @(negedge clk);
    wait_slot(AN_TENS0, s, f);
    n_vec++; if (!f || s !== SEG_TENS0) begin n_err++; $display("FAIL zero_tens found=%0d got=%h exp=%h", f, s, SEG_TENS0); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h40) begin n_err++; $display("FAIL zero_ones found=%0d got=%h exp=40", f, s); end
  endtask

  task automatic test_scan();
    logic [1:0] prev;
    int n;
    prev = bus.an;
    for (int i = 0; i < 3 * RD; i++) begin
      @(negedge clk);
      if (bus.an !== prev) break;
    end
    for (int k = 0; k < 2; k++) begin
      prev = bus.an;
      n = 0;
      for (int i = 0; i < 3 * RD; i++) begin
        @(negedge clk);
        n++;
        if (bus.an !== prev) break;
      end
      n_vec++; if (n != RD) begin n_err++; $display("FAIL scan_period got=%0d exp=%0d", n, RD); end
    end
  endtask

  task automatic test_convert_99();
    logic [6:0] s;
    bit f;
    int n;
    bus.count = 7'd99;
    count_busy(30, n);
    n_vec++; if (n != 10) begin n_err++; $display("FAIL busy_99 got=%0d exp=10", n); end
    wait_slot(AN_TENS, s, f);
    n_vec++; if (!f || s !== 7'h10) begin n_err++; $display("FAIL tens_99 found=%0d got=%h exp=10", f, s); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h10) begin n_err++; $display("FAIL ones_99 found=%0d got=%h exp=10", f, s); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s, e;
    bit f;
    int n;
    bus.count = 7'd57;
    f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.conv_busy === 1'b1) begin f = 1'b1; break; end
    end
    n_vec++; if (!f) begin n_err++; $display("FAIL b2b_start1 got=timeout exp=busy"); end
    bus.count = 7'd58;
    n = 0;
    while (bus.conv_busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    n_vec++; if (n != 6) begin n_err++; $display("FAIL b2b_busy57 got=%0d exp=6", n); end
    f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.conv_busy === 1'b1) begin f = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!f) begin n_err++; $display("FAIL b2b_start2 got=timeout exp=busy"); end
    e = (bus.an === AN_TENS) ? 7'h12 : 7'h78;
    n_vec++; if (bus.seg !== e) begin n_err++; $display("FAIL b2b_show57 an=%b got=%h exp=%h", bus.an, bus.seg, e); end
    n = 0;
    while (bus.conv_busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    n_vec++; if (n != 6) begin n_err++; $display("FAIL b2b_busy58 got=%0d exp=6", n); end
    repeat (5) @(negedge clk);
    wait_slot(AN_TENS, s, f);
    n_vec++; if (!f || s !== 7'h12) begin n_err++; $display("FAIL tens_58 found=%0d got=%h exp=12", f, s); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h00) begin n_err++; $display("FAIL ones_58 found=%0d got=%h exp=00", f, s); end
  endtask

  task automatic test_error();
    logic [6:0] s;
    bit f;
    int n;
    bus.count = 7'd120;
    count_busy(20, n);
    n_vec++; if (n != 0) begin n_err++; $display("FAIL err_busy got=%0d exp=0", n); end
    wait_slot(AN_TENS, s, f);
    n_vec++; if (!f || s !== 7'h3F) begin n_err++; $display("FAIL err_tens found=%0d got=%h exp=3f", f, s); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h3F) begin n_err++; $display("FAIL err_ones found=%0d got=%h exp=3f", f, s); end
    bus.count = 7'd5;
    repeat (20) @(negedge clk);
    wait_slot(AN_TENS0, s, f);
    n_vec++; if (!f || s !== SEG_TENS0) begin n_err++; $display("FAIL tens_05 found=%0d got=%h exp=%h", f, s, SEG_TENS0); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h12) begin n_err++; $display("FAIL ones_05 found=%0d got=%h exp=12", f, s); end
  endtask

  task automatic test_reset_mid_conv();
    logic [6:0] s;
    bit f;
    int n;
    bus.count = 7'd99;
    f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.conv_busy === 1'b1) begin f = 1'b1; break; end
    end
    n_vec++; if (!f) begin n_err++; $display("FAIL midrst_start got=timeout exp=busy"); end
    repeat (3) @(negedge clk);
    result_reset = 1'b1;
    #1;
    n_vec++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL midrst_seg got=%h exp=7f", bus.seg); end
    n_vec++; if (bus.an !== 2'b11) begin n_err++; $display("FAIL midrst_an got=%b exp=11", bus.an); end
    n_vec++; if (bus.conv_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", bus.conv_busy); end
    repeat (2) @(negedge clk);
    result_reset = 1'b0;
    count_busy(30, n);
    n_vec++; if (n != 10) begin n_err++; $display("FAIL midrst_reconv got=%0d exp=10", n); end
    wait_slot(AN_TENS, s, f);
    n_vec++; if (!f || s !== 7'h10) begin n_err++; $display("FAIL midrst_tens found=%0d got=%h exp=10", f, s); end
    wait_slot(AN_ONES, s, f);
    n_vec++; if (!f || s !== 7'h10) begin n_err++; $display("FAIL midrst_ones found=%0d got=%h exp=10", f, s); end
  endtask

  task automatic test_buzzer();
    int n;
    @(negedge clk);
    bus.buzzer = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.buzzer_out === 1'b1) n++;
      if (i == 4) bus.buzzer = 1'b0;
    end
    n_vec++; if (n != BS) begin n_err++; $display("FAIL buzz_single got=%0d exp=%0d", n, BS); end
    n_vec++; if (bus.buzzer_out !== 1'b0) begin n_err++; $display("FAIL buzz_idle got=%b exp=0", bus.buzzer_out); end
    bus.buzzer = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.buzzer_out === 1'b1) n++;
      if (i == 3) bus.buzzer = 1'b0;
      if (i == 7) bus.buzzer = 1'b1;
    end
    bus.buzzer = 1'b0;
    n_vec++; if (n != 8 + BS) begin n_err++; $display("FAIL buzz_retrig got=%0d exp=%0d", n, 8 + BS); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert_99();
    test_back_to_back();
    test_error();
    test_reset_mid_conv();
    test_buzzer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
